main_ram_arbiter: RTL and testbench
===================================

Name: main_ram_arbiter

Overview:
- Shares the single-port main data RAM (12-bit address, 16-bit data) between two requesters.
- Port 0 is the processor and has priority. Port 1 is the auxiliary master (program/data loader, debug readback).
- One access is granted per cycle, with fixed priority plus starvation override and a bounded port-1 lock for bursts.
- Sits between the requesters and the RAM macro and returns read data to the issuing port after the RAM read latency.

Parameters:
- AW, 12, address width
- DW, 16, data width
- RD_LAT, 1, cycles from an issued read to valid m_q (1..4)
- MAX_WAIT, 4, port-1 denied cycles before it overrides port 0; 0 = never override
- MAX_LOCK, 8, maximum consecutive locked port-1 grants

Ports:
- clock  in  1  system clock; all state updates on rising edge
- n_reset  in  1  asynchronous, active-low reset
- req0  in  1  port 0 access request
- wren0  in  1  port 0 write (1) / read (0)
- addr0  in  AW  port 0 address
- wdata0  in  DW  port 0 write data
- gnt0  out  1  port 0 access issued this cycle
- rvalid0  out  1  port 0 read data valid
- rdata0  out  DW  port 0 read data
- req1, wren1, addr1, wdata1  in  1/1/AW/DW  port 1 request, same meaning as port 0
- lock1  in  1  port 1 requests to keep the grant for following cycles
- gnt1, rvalid1, rdata1  out  1/1/DW  port 1 grant, read valid, read data
- m_addr  out  AW  RAM address
- m_data  out  DW  RAM write data
- m_wren  out  1  RAM write enable
- m_q  in  DW  RAM read data
- conflict_cnt  out  16  saturating count of cycles with req0 and req1 both high

Behaviour:
- Grant is combinational within the cycle; the access is issued in the same cycle the grant is high. A requester holds its request until it sees its grant. gnt0 and gnt1 are never both 1.
- Arbitration order for the current cycle:
  1. Locked: if locked=1, req1=1 and lock_cnt<MAX_LOCK, grant port 1.
  2. Starved: otherwise, if req1=1 and MAX_WAIT≠0 and wait_cnt≥MAX_WAIT, grant port 1.
  3. Normal: otherwise, if req0=1 grant port 0; else if req1=1 grant port 1.
- RAM mux: when gnt1=1, m_* is driven from port 1; in all other cycles from port 0. m_wren = (gnt0 & wren0) | (gnt1 & wren1), so m_wren is 0 when nothing is granted.
- wait_cnt (saturating at MAX_WAIT):
  - cleared on gnt1;
  - incremented when req1=1 and gnt1=0;
  - held when req1=0.
- Lock state:
  - locked is set after a cycle with gnt1=1 and lock1=1.
  - It is cleared after any cycle where req1=0 or lock1=0, or where lock_cnt reaches MAX_LOCK.
  - lock_cnt counts locked grants. When the cap is hit, port 1 loses the bus for at least one cycle if req0=1; lock_cnt resets when locked clears.
- Read return:
  - A shift register RD_LAT deep carries {valid, owner} for each granted read; writes carry valid=0.
  - At the output end, rvalidN=1 exactly RD_LAT cycles after gntN with wrenN=0.
  - rdataN = m_q when rvalidN=1; otherwise rdataN holds its last value.
  - Back-to-back reads from mixed owners return in issue order, one per cycle.
- conflict_cnt increments on every cycle with req0&req1 and saturates at 16'hFFFF.
- Reset (n_reset=0, asynchronous):
  - wait_cnt=0, locked=0, lock_cnt=0, conflict_cnt=0;
  - read pipeline cleared; rvalid0=rvalid1=0; rdata0=rdata1=0.
  - Grants follow the combinational rules, but requesters must keep req low during reset.
  - Reads in flight when reset asserts are discarded and never return rvalid.
- Simultaneous events:
  - Starvation and lock both pending: port 1 is granted; this counts as a lock grant only if locked=1.
  - req1 drops while locked: the lock clears and port 0 is granted the same cycle if requesting.

Test Plan:
- Single requests: req0 read at 12'h010 with RAM preloaded to 16'hBEEF → gnt0 in the same cycle, rvalid0=1 and rdata0=16'hBEEF after RD_LAT=1 cycle, rvalid1 stays 0. Repeat on port 1 with a write of 16'h1234 to 12'h020, then read it back → 16'h1234.
- Starvation: req0 and req1 held high continuously with MAX_WAIT=4 → gnt0 for 4 cycles, gnt1 on the 5th, then gnt0 resumes. Pattern repeats every 5 cycles; conflict_cnt increments by 1 each cycle.
- Lock cap: req1=lock1=1 with port 1 granted, req0 high throughout, MAX_LOCK=8 → 8 consecutive locked gnt1 cycles after the initial grant, then gnt0 for at least 1 cycle.
- Interleaved reads with RD_LAT=3: p0@A, p1@B, p0@C issued on consecutive cycles → rvalid0, rvalid1, rvalid0 on cycles +3, +4, +5 with the matching data; no grant gaps.
- Async reset mid-read: drop n_reset between issue and return → rvalid never asserts for that read, and all counters read 0 immediately without waiting for a clock edge.
- Saturation: force 70000 conflict cycles → conflict_cnt=16'hFFFF and stays there.

Source files
------------

// File: rtl/main_ram_arbiter_if.sv
// Requester and RAM-side signals of the main data RAM arbiter.
// The slave modport is the arbiter's view; master is the requesters/RAM view.
interface main_ram_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          req0;
    logic          wren0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          wren1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          lock1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;

    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_wren;
    logic [DW-1:0] m_q;

    modport slave (
        input  req0, wren0, addr0, wdata0,
        input  req1, wren1, addr1, wdata1, lock1,
        input  m_q,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output m_addr, m_data, m_wren
    );

    modport master (
        output req0, wren0, addr0, wdata0,
        output req1, wren1, addr1, wdata1, lock1,
        output m_q,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  m_addr, m_data, m_wren
    );
endinterface

// File: rtl/main_ram_arbiter.sv
// Two-port arbiter for the single-port main data RAM: fixed priority to port 0,
// starvation override and bounded burst lock for port 1, in-order read return.
module main_ram_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic              clock,
    input  logic              n_reset,
    main_ram_arbiter_if.slave bus,
    output logic [15:0]       conflict_cnt
);

    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int LW = $clog2(MAX_LOCK + 2);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);

    typedef enum logic {S_OPEN, S_LOCKED} lock_state_t;

    lock_state_t   lock_state, lock_state_nx;
    logic [LW-1:0] lock_cnt, lock_cnt_nx, lock_cnt_inc;
    logic [WW-1:0] wait_cnt;
    logic          lock_ok, starve, gnt0_c, gnt1_c;
    logic          rd_vld_p [RD_LAT];
    logic          rd_own_p [RD_LAT];
    logic          rvalid0_c, rvalid1_c;
    logic [DW-1:0] rdata0_q, rdata1_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [WW-1:0] sat_inc_wait(input logic [WW-1:0] v);
        return (v >= WAIT_MAX) ? WAIT_MAX : v + WW'(1);
    endfunction

    // Arbitration: lock, then starvation override, then fixed priority.
    always_comb begin
        lock_ok = (lock_state == S_LOCKED) && bus.req1 && (lock_cnt < LOCK_MAX);
        starve  = bus.req1 && (MAX_WAIT != 0) && (wait_cnt >= WAIT_MAX);
        gnt1_c  = lock_ok || starve || (bus.req1 && !bus.req0);
        gnt0_c  = bus.req0 && !gnt1_c;
    end

    assign bus.gnt0   = gnt0_c;
    assign bus.gnt1   = gnt1_c;
    assign bus.m_addr = gnt1_c ? bus.addr1  : bus.addr0;
    assign bus.m_data = gnt1_c ? bus.wdata1 : bus.wdata0;
    assign bus.m_wren = (gnt0_c && bus.wren0) || (gnt1_c && bus.wren1);

    assign lock_cnt_inc = lock_cnt + LW'(1);

    always_comb begin
        lock_state_nx = lock_state;
        lock_cnt_nx   = lock_cnt;
        case (lock_state)
            S_OPEN: begin
                if (gnt1_c && bus.lock1) begin
                    lock_state_nx = S_LOCKED;
                    lock_cnt_nx   = '0;
                end
            end
            S_LOCKED: begin
                // Releasing at the cap guarantees port 0 at least one slot.
                if (!bus.req1 || !bus.lock1 || (lock_cnt >= LOCK_MAX) ||
                    (lock_ok && (lock_cnt_inc >= LOCK_MAX))) begin
                    lock_state_nx = S_OPEN;
                    lock_cnt_nx   = '0;
                end else if (lock_ok) begin
                    lock_cnt_nx = lock_cnt_inc;
                end
            end
            default: begin
                lock_state_nx = S_OPEN;
                lock_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            lock_state   <= S_OPEN;
            lock_cnt     <= '0;
            wait_cnt     <= '0;
            conflict_cnt <= '0;
        end else begin
            lock_state <= lock_state_nx;
            lock_cnt   <= lock_cnt_nx;
            if (gnt1_c)
                wait_cnt <= '0;
            else if (bus.req1)
                wait_cnt <= sat_inc_wait(wait_cnt);
            if (bus.req0 && bus.req1)
                conflict_cnt <= sat_inc16(conflict_cnt);
        end
    end

    // Read return pipeline: stage 0 captures the issue, last stage meets m_q.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_vld_p[i] <= 1'b0;
                rd_own_p[i] <= 1'b0;
            end
        end else begin
            rd_vld_p[0] <= (gnt0_c && !bus.wren0) || (gnt1_c && !bus.wren1);
            rd_own_p[0] <= gnt1_c;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
                rd_own_p[i] <= rd_own_p[i-1];
            end
        end
    end

    assign rvalid0_c = rd_vld_p[RD_LAT-1] && !rd_own_p[RD_LAT-1];
    assign rvalid1_c = rd_vld_p[RD_LAT-1] &&  rd_own_p[RD_LAT-1];

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvalid0_c) rdata0_q <= bus.m_q;
            if (rvalid1_c) rdata1_q <= bus.m_q;
        end
    end

    assign bus.rvalid0 = rvalid0_c;
    assign bus.rvalid1 = rvalid1_c;
    assign bus.rdata0  = rvalid0_c ? bus.m_q : rdata0_q;
    assign bus.rdata1  = rvalid1_c ? bus.m_q : rdata1_q;

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Randomized and directed bench for main_ram_arbiter with a RAM model,
// a rule-level reference model and a decoupled read-return scoreboard.
module tb_main_ram_arbiter;
    localparam int AW       = 12;
    localparam int DW       = 16;
    localparam int RD_LAT   = 3;
    localparam int MAX_WAIT = 4;
    localparam int MAX_LOCK = 8;
    localparam int DEPTH    = 1 << AW;

    logic        clock   = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] conflict_cnt;

    main_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    main_ram_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .bus         (bus),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        case (a)
            12'h010: return 16'hBEEF;
            12'h030: return 16'h1111;
            12'h040: return 16'h2222;
            12'h050: return 16'h3333;
            default: return {4'hC, a};
        endcase
    endfunction

    // RAM macro model: RD_LAT-cycle read latency, initialised while in reset.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] rq  [RD_LAT];
    always @(posedge clock) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(AW'(i));
        end else if (bus.m_wren) begin
            ram[bus.m_addr] <= bus.m_data;
        end
        rq[0] <= ram[bus.m_addr];
        for (int i = 1; i < RD_LAT; i++) rq[i] <= rq[i-1];
    end
    assign bus.m_q = rq[RD_LAT-1];

    typedef struct {
        int            owner;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            m_wait, m_lcnt, m_conf;
    bit            m_locked;
    bit            seen_g0, seen_g1;
    bit            track = 1'b0;
    int            run, max_run, g1_cnt;

    // Reference model: decides the winner from the arbitration rules, keeps a
    // shadow memory and queues the expected read returns.
    always @(negedge clock) begin : model
        int            winner;
        bit            lock_grant;
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] wd;
        if (!n_reset) begin
            m_wait = 0; m_lcnt = 0; m_conf = 0; m_locked = 1'b0;
            seen_g0 = 1'b0; seen_g1 = 1'b0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(AW'(i));
            check("rst_conflict_cnt", conflict_cnt, 0);
            check("rst_gnt", {bus.gnt0, bus.gnt1}, 0);
        end else begin
            lock_grant = m_locked && bus.req1 && (m_lcnt < MAX_LOCK);
            if (lock_grant || (bus.req1 && MAX_WAIT != 0 && m_wait >= MAX_WAIT)) winner = 1;
            else if (bus.req0) winner = 0;
            else if (bus.req1) winner = 1;
            else winner = -1;

            check("gnt0", bus.gnt0, winner == 0);
            check("gnt1", bus.gnt1, winner == 1);
            check("conflict_cnt", conflict_cnt, m_conf);

            if (winner >= 0) begin
                a  = (winner == 1) ? bus.addr1  : bus.addr0;
                w  = (winner == 1) ? bus.wren1  : bus.wren0;
                wd = (winner == 1) ? bus.wdata1 : bus.wdata0;
                check("m_addr", bus.m_addr, a);
                check("m_wren", bus.m_wren, w);
                if (w) begin
                    check("m_data", bus.m_data, wd);
                    ref_mem[a] = wd;
                end else begin
                    exp_q.push_back('{winner, ref_mem[a], cyc + RD_LAT});
                end
            end else begin
                check("m_wren_idle", bus.m_wren, 0);
            end

            if (winner == 1) m_wait = 0;
            else if (bus.req1 && m_wait < MAX_WAIT) m_wait++;

            if (m_locked) begin
                if (!bus.req1 || !bus.lock1 || (lock_grant && m_lcnt + 1 >= MAX_LOCK)) begin
                    m_locked = 1'b0;
                    m_lcnt   = 0;
                end else if (lock_grant) begin
                    m_lcnt++;
                end
            end else if (winner == 1 && bus.lock1) begin
                m_locked = 1'b1;
                m_lcnt   = 0;
            end

            if (bus.req0 && bus.req1 && m_conf < 65535) m_conf++;
            seen_g0 = bus.gnt0;
            seen_g1 = bus.gnt1;
        end

        if (!track) begin
            run = 0; max_run = 0; g1_cnt = 0;
        end else begin
            if (bus.gnt1) begin run++; g1_cnt++; end
            else run = 0;
            if (run > max_run) max_run = run;
        end
    end

    int            rd_ptr = 0;
    logic [DW-1:0] h0, h1;

    // Monitor: compares each read return against the oldest queued expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!n_reset) begin
            rd_ptr = exp_q.size();
            h0 = '0;
            h1 = '0;
            check("rst_rvalid", {bus.rvalid0, bus.rvalid1}, 0);
        end else if (rd_ptr < exp_q.size() && exp_q[rd_ptr].due == cyc) begin
            e = exp_q[rd_ptr];
            rd_ptr++;
            check("rvalid0", bus.rvalid0, e.owner == 0);
            check("rvalid1", bus.rvalid1, e.owner == 1);
            if (e.owner == 0) h0 = e.data;
            else              h1 = e.data;
        end else begin
            check("rvalid_idle", {bus.rvalid0, bus.rvalid1}, 0);
        end
        check("rdata0", bus.rdata0, h0);
        check("rdata1", bus.rdata1, h1);
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic drive0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req0 = r; bus.wren0 = w; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic l);
        bus.req1 = r; bus.wren1 = w; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = l;
    endtask

    task automatic idle(input int n);
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0, 1'b0);
        repeat (n) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0, 1'b0);
        repeat (3) @(posedge clock);
        #2 n_reset = 1'b1;
        idle(2);

        // Single requests on each port
        drive0(1'b1, 1'b0, 12'h010, '0);
        step();
        idle(RD_LAT + 2);
        check("rdata0_beef", bus.rdata0, 16'hBEEF);
        drive1(1'b1, 1'b1, 12'h020, 16'h1234, 1'b0);
        step();
        drive1(1'b1, 1'b0, 12'h020, '0, 1'b0);
        step();
        idle(RD_LAT + 2);
        check("rdata1_readback", bus.rdata1, 16'h1234);

        // Starvation: both requesting continuously, no lock
        track = 1'b1;
        drive0(1'b1, 1'b0, 12'h030, '0);
        drive1(1'b1, 1'b0, 12'h040, '0, 1'b0);
        repeat (20) step();
        check("starve_gnt1_count", g1_cnt, 4);
        check("starve_max_run", max_run, 1);
        track = 1'b0;
        idle(2);

        // Lock cap with port 0 requesting throughout
        track = 1'b1;
        drive0(1'b1, 1'b0, 12'h050, '0);
        drive1(1'b1, 1'b0, 12'h040, '0, 1'b1);
        repeat (30) step();
        check("lock_max_run", max_run, MAX_LOCK + 1);
        check("lock_gnt1_count", g1_cnt, 2 * (MAX_LOCK + 1));
        track = 1'b0;
        idle(2);

        // Interleaved reads from both owners on consecutive cycles
        drive0(1'b1, 1'b0, 12'h030, '0);
        step();
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b1, 1'b0, 12'h040, '0, 1'b0);
        step();
        drive1(1'b0, 1'b0, '0, '0, 1'b0);
        drive0(1'b1, 1'b0, 12'h050, '0);
        step();
        idle(RD_LAT + 3);

        // Randomized traffic; a requester keeps its request until granted
        for (int i = 0; i < 3000; i++) begin
            if (!(bus.req0 && !seen_g0))
                drive0(($urandom_range(0, 2) != 0), 1'($urandom), AW'($urandom_range(0, 31)), DW'($urandom));
            if (!(bus.req1 && !seen_g1))
                drive1(($urandom_range(0, 2) != 0), 1'($urandom), AW'($urandom_range(0, 31)), DW'($urandom),
                       bus.lock1);
            bus.lock1 = ($urandom_range(0, 3) != 0);
            step();
        end
        idle(RD_LAT + 2);

        // Asynchronous reset between read issue and return
        drive0(1'b1, 1'b0, 12'h010, '0);
        drive1(1'b1, 1'b0, 12'h040, '0, 1'b0);
        step();
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0, 1'b0);
        #1 n_reset = 1'b0;
        #1;
        check("async_rst_conflict_cnt", conflict_cnt, 0);
        check("async_rst_rvalid", {bus.rvalid0, bus.rvalid1}, 0);
        check("async_rst_rdata0", bus.rdata0, 0);
        repeat (3) step();
        n_reset = 1'b1;
        idle(RD_LAT + 3);

        // Conflict counter saturation
        drive0(1'b1, 1'b1, 12'h100, 16'hAAAA);
        drive1(1'b1, 1'b1, 12'h101, 16'h5555, 1'b0);
        repeat (70000) step();
        check("conflict_saturated", conflict_cnt, 16'hFFFF);
        repeat (3) step();
        check("conflict_stays_saturated", conflict_cnt, 16'hFFFF);
        idle(RD_LAT + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
